stmt_lowerer_seq_packer: RTL and testbench
==========================================

Name: stmt_lowerer_seq_packer

Overview:
- Sequential byte-to-word packer that sits downstream of the combinational statement-lowering cases.
- It provides the always_ff counterpart for the converter flow. It exercises nonblocking assignments, case-based FSM lowering, and indexed LHS part-selects (word[idx +: W]) under a clock edge.
- It accepts one DATA_W-bit lane per handshake, assembles LANES lanes into one word, and emits the word over a valid/ready interface.
- It is also a functional block in its own right: its behaviour is checked after conversion by simulation equivalence.

Parameters:
- DATA_W, 8, width of one input lane in bits.
- LANES, 4, lanes per output word (2..16). The lane index width is clog2(LANES).
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  upstream lane valid
- in_data  input  DATA_W  lane payload
- in_last  input  1  closes the current word early (partial word)
- in_ready  output  1  packer can accept a lane this cycle
- out_valid  output  1  packed word available
- out_data  output  DATA_W*LANES  packed word; lane k occupies bits [k*DATA_W +: DATA_W]
- out_keep  output  LANES  bit k set when lane k holds accepted data
- out_ready  input  1  downstream accepts the word
- word_count  output  CNT_W  number of words handed off downstream, wraps modulo 2^CNT_W

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n sampled low at a rising clk edge). All state is updated only at the rising edge.
- Reset values: state=IDLE, lane index=0, out_valid=0, out_data=0, out_keep=0, word_count=0. in_ready is 1 while rst_n is low, because it derives from state.
- FSM states:
  - IDLE: no lanes held.
  - FILL: 1..LANES-1 lanes held.
  - HOLD: word presented downstream.
- in_ready = (state != HOLD), driven combinationally from state only. It never depends on in_valid or out_ready.
- Accept = in_valid & in_ready. On accept in IDLE or FILL, at the edge:
  - out_data[idx*DATA_W +: DATA_W] <= in_data
  - out_keep[idx] <= 1
- After an accept, the next state depends on the lane index and in_last:
  - idx==LANES-1, or in_last=1: state <= HOLD, out_valid <= 1, idx <= 0.
  - Otherwise: idx <= idx+1, state <= FILL.
- out_valid rises on the edge after the completing accept, so latency is 1 cycle from the last lane to out_valid.
- HOLD:
  - out_data, out_keep and out_valid stay stable until out_ready=1.
  - On out_valid & out_ready:
    - out_valid <= 0, out_data <= 0, out_keep <= 0, state <= IDLE
    - word_count <= word_count+1, wrapping from 2^CNT_W-1 to 0.
- No bypass. A lane offered in the same cycle as the downstream handshake is not accepted (in_ready=0 in HOLD). Peak throughput is therefore one word per LANES+1 cycles.
- in_valid while in HOLD is ignored. Upstream holds in_data and in_last until in_ready=1.
- Lanes never written stay 0 and have keep bit 0.
- A partial word with in_last gives out_keep = contiguous ones from bit 0.
- in_last with idx=0 in IDLE produces a single-lane word with keep = 1 (0001 at LANES=4).
- out_ready high while out_valid=0 has no effect.
- in_last while in_valid=0 is ignored.
- Reset mid-word or in HOLD discards the partial or pending word immediately at that edge. word_count is not incremented for the discarded word.
- No X propagation is permitted: every register has an explicit reset value and a defined next value in every state, with a default branch in the state case.

Test Plan:
- Full word: reset, then 4 lanes with in_valid held, in_data=11,22,33,44, out_ready=0.
  - Expected: out_valid=1 on the cycle after the 4th accept, out_data=0x44332211, out_keep=1111, in_ready=0.
  - Then out_ready=1 for 1 cycle. Expected: out_valid=0, word_count=1, in_ready=1.
- Early last: lanes AA, BB with in_last on BB.
  - Expected: out_data=0x0000BBAA, out_keep=0011.
  - Single lane 5A with in_last from IDLE. Expected: out_data=0x0000005A, out_keep=0001.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1, in_data=77.
  - Expected: out_data unchanged and in_ready=0 throughout.
  - Then release out_ready. Expected: 77 is accepted only on the cycle after the handshake.
- Reset mid-operation: accept 2 lanes, then pulse rst_n=0 for one edge.
  - Expected: out_keep=0, idx=0, word_count unchanged.
  - Then 4 new lanes. Expected: word contains only the new lanes.
- Counter wrap: CNT_W=2, emit 5 words. Expected: word_count sequence 1,2,3,0,1.
- Random streaming: random in_valid/out_ready over 2000 cycles. Expected: matches a reference packing model word-for-word, including keep.

Source files
------------

// File: rtl/stmt_lowerer_seq_packer.sv
// Sequential byte-to-word packer: collects DATA_W-bit lanes into a LANES-wide word
// and presents it on a valid/ready output, closing early on in_last.
module stmt_lowerer_seq_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATA_W*LANES-1:0]   out_data,
  output logic [LANES-1:0]          out_keep,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          word_count
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;

  // Depends on state alone so upstream never sees a combinational path from out_ready.
  assign in_ready = (state != S_HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_FILL: begin
          if (in_valid) begin
            out_data[idx*DATA_W +: DATA_W] <= in_data;
            out_keep[idx]                  <= 1'b1;
            if ((idx == LAST_IDX) || in_last) begin
              state     <= S_HOLD;
              out_valid <= 1'b1;
              idx       <= '0;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FILL;
            end
          end
        end
        S_HOLD: begin
          // No bypass: the cycle of the downstream handshake accepts no new lane.
          if (out_ready) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            word_count <= word_count + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_keep  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stmt_lowerer_seq_packer.sv
// Self-checking bench for stmt_lowerer_seq_packer: directed scenarios followed by
// randomized streaming, compared every cycle against a lane-list reference model.
module tb_stmt_lowerer_seq_packer;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int CNT_W  = 16;
  localparam int W      = DATA_W * LANES;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [LANES-1:0]  out_keep;
  logic              out_ready;
  logic [CNT_W-1:0]  word_count;

  logic              in_ready2;
  logic              out_valid2;
  logic [W-1:0]      out_data2;
  logic [LANES-1:0]  out_keep2;
  logic [1:0]        word_count2;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the list of lanes held so far, whether the word is presented, words emitted.
  logic [DATA_W-1:0] m_lane [LANES];
  int                m_n;
  bit                m_held;
  int unsigned       m_cnt;

  always #5 clk = ~clk;

  stmt_lowerer_seq_packer #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .out_ready(out_ready), .word_count(word_count)
  );

  // Narrow counter instance shares all inputs so wraparound can be observed quickly.
  stmt_lowerer_seq_packer #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2), .out_keep(out_keep2),
    .out_ready(out_ready), .word_count(word_count2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    if (!rst_n) begin
      m_held = 1'b0;
      m_n    = 0;
      m_cnt  = 0;
      for (int k = 0; k < LANES; k++) m_lane[k] = '0;
    end else if (m_held) begin
      if (out_ready) begin
        m_held = 1'b0;
        m_n    = 0;
        m_cnt  = m_cnt + 1;
        for (int k = 0; k < LANES; k++) m_lane[k] = '0;
      end
    end else if (in_valid) begin
      m_lane[m_n] = in_data;
      m_n = m_n + 1;
      if (m_n == LANES || in_last) m_held = 1'b1;
    end
  endtask

  task automatic checkModel();
    logic [W-1:0]     exp_data;
    logic [LANES-1:0] exp_keep;
    exp_data = '0;
    exp_keep = '0;
    for (int k = 0; k < LANES; k++) begin
      exp_data = exp_data | (W'(m_lane[k]) << (k * DATA_W));
      if (k < m_n) exp_keep[k] = 1'b1;
    end
    checkOutput("out_valid", 64'(out_valid), 64'(m_held));
    checkOutput("in_ready", 64'(in_ready), 64'(!m_held));
    checkOutput("out_data", 64'(out_data), 64'(exp_data));
    checkOutput("out_keep", 64'(out_keep), 64'(exp_keep));
    checkOutput("word_count", 64'(word_count), 64'(m_cnt % 65536));
    checkOutput("word_count_w2", 64'(word_count2), 64'(m_cnt % 4));
    checkOutput("out_data_w2", 64'(out_data2), 64'(exp_data));
    checkOutput("in_ready_w2", 64'(in_ready2), 64'(!m_held));
  endtask

  // Drive one cycle of inputs, advance the model and the DUT by one edge, then compare.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic l,
                               input logic ordy, input logic rn);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    rst_n     = rn;
    modelEdge();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  logic [1:0] wrap_seq [5];

  initial begin
    logic              v, l, o, r;
    logic [DATA_W-1:0] d;

    wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;
    m_n = 0; m_held = 1'b0; m_cnt = 0;
    for (int k = 0; k < LANES; k++) m_lane[k] = '0;
    in_valid = 0; in_data = '0; in_last = 0; out_ready = 0; rst_n = 0;

    $display("[TB] reset");
    applyStimulus(0, 8'h00, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("reset_keep", 64'(out_keep), 64'h0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'h1);

    $display("[TB] reset mid-word");
    applyStimulus(1, 8'h01, 0, 0, 1);
    applyStimulus(1, 8'h02, 0, 0, 1);
    checkOutput("mid_keep_before", 64'(out_keep), 64'h3);
    applyStimulus(1, 8'h03, 0, 0, 0);
    checkOutput("mid_keep_after", 64'(out_keep), 64'h0);
    checkOutput("mid_count_after", 64'(word_count), 64'h0);
    applyStimulus(1, 8'hA1, 0, 0, 1);
    applyStimulus(1, 8'hA2, 0, 0, 1);
    applyStimulus(1, 8'hA3, 0, 0, 1);
    applyStimulus(1, 8'hA4, 0, 0, 1);
    checkOutput("mid_new_word", 64'(out_data), 64'hA4A3A2A1);
    applyStimulus(0, 8'h00, 0, 1, 1);

    $display("[TB] full word");
    applyStimulus(1, 8'h11, 0, 0, 1);
    applyStimulus(1, 8'h22, 0, 0, 1);
    applyStimulus(1, 8'h33, 0, 0, 1);
    checkOutput("full_not_yet_valid", 64'(out_valid), 64'h0);
    applyStimulus(1, 8'h44, 0, 0, 1);
    checkOutput("full_valid", 64'(out_valid), 64'h1);
    checkOutput("full_data", 64'(out_data), 64'h44332211);
    checkOutput("full_keep", 64'(out_keep), 64'hF);
    checkOutput("full_in_ready", 64'(in_ready), 64'h0);
    applyStimulus(0, 8'h00, 0, 1, 1);
    checkOutput("full_release_valid", 64'(out_valid), 64'h0);
    checkOutput("full_release_count", 64'(word_count), 64'h2);
    checkOutput("full_release_ready", 64'(in_ready), 64'h1);

    $display("[TB] early last");
    applyStimulus(1, 8'hAA, 0, 0, 1);
    applyStimulus(1, 8'hBB, 1, 0, 1);
    checkOutput("early_data", 64'(out_data), 64'h0000BBAA);
    checkOutput("early_keep", 64'(out_keep), 64'h3);
    applyStimulus(0, 8'h00, 0, 1, 1);
    applyStimulus(0, 8'h00, 1, 1, 1);
    checkOutput("last_without_valid", 64'(out_keep), 64'h0);
    applyStimulus(1, 8'h5A, 1, 0, 1);
    checkOutput("single_data", 64'(out_data), 64'h0000005A);
    checkOutput("single_keep", 64'(out_keep), 64'h1);
    applyStimulus(0, 8'h00, 0, 1, 1);

    $display("[TB] backpressure");
    applyStimulus(1, 8'h01, 0, 0, 1);
    applyStimulus(1, 8'h02, 0, 0, 1);
    applyStimulus(1, 8'h03, 0, 0, 1);
    applyStimulus(1, 8'h04, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'h77, 0, 0, 1);
      checkOutput("bp_hold_data", 64'(out_data), 64'h04030201);
      checkOutput("bp_in_ready", 64'(in_ready), 64'h0);
    end
    applyStimulus(1, 8'h77, 0, 1, 1);
    checkOutput("bp_no_bypass_keep", 64'(out_keep), 64'h0);
    applyStimulus(1, 8'h77, 0, 0, 1);
    checkOutput("bp_accept_keep", 64'(out_keep), 64'h1);
    checkOutput("bp_accept_data", 64'(out_data), 64'h00000077);
    applyStimulus(1, 8'h78, 1, 0, 1);
    applyStimulus(0, 8'h00, 0, 1, 1);

    $display("[TB] counter wrap");
    applyStimulus(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'(i + 1), 1, 0, 1);
      applyStimulus(0, 8'h00, 0, 1, 1);
      checkOutput("wrap_count", 64'(word_count2), 64'(wrap_seq[i]));
    end

    $display("[TB] random streaming");
    v = 0; d = '0; l = 0;
    for (int c = 0; c < 2000; c++) begin
      // Upstream keeps an offered lane steady until the packer can take it.
      if (!(v && m_held)) begin
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        l = ($urandom_range(0, 5) == 0);
      end
      o = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 499) != 0);
      applyStimulus(v, d, l, o, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
